// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 19-bit CPU: owns the PC, fetches over a
// req/ack handshake, decodes register/ALU fields and strobes rf_we once per ALU instruction.
module cpu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [18:0]     imem_rdata,
    output logic [3:0]      rf_raddr1,
    output logic [3:0]      rf_raddr2,
    output logic [3:0]      rf_waddr,
    output logic            rf_we,
    output logic [2:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [18:2]     ir_q, ir_d;
    logic [15:0]     retired_q, retired_d;
    logic [4:0]      opcode;
    logic            is_alu;
    logic            is_halt;
    logic            in_exec;
    logic            unused_rdata_bits;

    // ir[1:0] carries no information, so those bits are never captured.
    assign unused_rdata_bits = ^imem_rdata[1:0];

    assign opcode  = ir_q[18:14];
    assign is_alu  = (opcode[4:2] == 3'b000);
    assign is_halt = (opcode == 5'b11111);
    assign in_exec = (state_q == S_DECODE) || (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata[18:2];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_halt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d      = pc_q + PC_W'(1);
                retired_d = retired_q + 16'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decode only from registered state, pc and ir; inputs never reach them directly.
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign rf_raddr1 = ir_q[9:6];
    assign rf_raddr2 = ir_q[5:2];
    assign rf_waddr  = ir_q[13:10];
    assign rf_we     = (state_q == S_WRITEBACK) && is_alu;
    assign illegal   = (state_q == S_WRITEBACK) && !is_alu;
    assign alu_op    = (in_exec && is_alu) ? {1'b0, opcode[1:0]} : 3'b000;
    assign busy      = (state_q == S_FETCH) || in_exec;
    assign halted    = (state_q == S_HALT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: an 8-bit-PC instance for the main scenarios and a
// 2-bit-PC instance for program-counter wrap.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_ack;
    logic [18:0] imem_rdata;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we, busy, halted, illegal;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    logic        start_w;
    logic        ack_w;
    logic [18:0] rdata_w;
    logic        req_w;
    logic [1:0]  addr_w;
    logic [3:0]  raddr1_w, raddr2_w, waddr_w;
    logic        we_w, busy_w, halted_w, illegal_w;
    logic [2:0]  alu_op_w;
    logic [15:0] retired_w;

    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.PC_W(8), .RESET_PC(8'd0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
        .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
    );

    cpu_sequencer #(.PC_W(2), .RESET_PC(2'd0)) dut_w (
        .clk(clk), .rst(rst), .start(start_w),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
        .rf_raddr1(raddr1_w), .rf_raddr2(raddr2_w), .rf_waddr(waddr_w), .rf_we(we_w),
        .alu_op(alu_op_w), .busy(busy_w), .halted(halted_w), .illegal(illegal_w), .retired(retired_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [18:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 2'b11};
    endfunction

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
        checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %0h exp 0", imem_addr); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_busy_halted got %0b%0b exp 00", busy, halted); end
        checks++; if (rf_we !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_we_ill got %0b%0b exp 00", rf_we, illegal); end
        checks++; if (alu_op !== 3'd0) begin errors++; $display("FAIL rst_aluop got %0h exp 0", alu_op); end
        checks++; if ({rf_waddr, rf_raddr1, rf_raddr2} !== 12'h000) begin errors++; $display("FAIL rst_regaddr got %0h exp 0", {rf_waddr, rf_raddr1, rf_raddr2}); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rst_retired got %0h exp 0", retired); end
        checks++; if (addr_w !== 2'd0 || req_w !== 1'b0) begin errors++; $display("FAIL rst_w got addr %0h req %0b exp 0 0", addr_w, req_w); end
    endtask

    task automatic test_add();
        do_reset();
        imem_rdata = 19'b00000_0011_0001_0010_00;
        imem_ack   = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("FAIL add_fetch got req %0b addr %0h exp 1 0", imem_req, imem_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %0b exp 1", busy); end
        step();
        checks++; if (imem_req !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL add_decode got req %0b we %0b exp 0 0", imem_req, rf_we); end
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL add_exec_we got %0b exp 0", rf_we); end
        step();
        checks++; if (rf_we !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL add_wb_we got we %0b ill %0b exp 1 0", rf_we, illegal); end
        checks++; if (rf_waddr !== 4'd3 || rf_raddr1 !== 4'd1 || rf_raddr2 !== 4'd2) begin errors++; $display("FAIL add_regs got %0h %0h %0h exp 3 1 2", rf_waddr, rf_raddr1, rf_raddr2); end
        checks++; if (alu_op !== 3'b000) begin errors++; $display("FAIL add_aluop got %0h exp 0", alu_op); end
        imem_ack = 1'b0;
        step();
        checks++; if (rf_we !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL add_next got we %0b req %0b exp 0 1", rf_we, imem_req); end
        checks++; if (imem_addr !== 8'd1 || retired !== 16'd1) begin errors++; $display("FAIL add_pc_ret got pc %0h ret %0h exp 1 1", imem_addr, retired); end
    endtask

    task automatic test_wait_states();
        int we_cnt;
        int we_cyc;
        int bad_fetch;
        logic [3:0] wa;
        we_cnt = 0; we_cyc = 0; bad_fetch = 0; wa = 4'd0;
        do_reset();
        imem_rdata = enc(5'b00000, 4'd5, 4'd6, 4'd7);
        imem_ack   = 1'b0;
        start      = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            if (c <= 4 && (imem_req !== 1'b1 || imem_addr !== 8'd0)) bad_fetch++;
            if (rf_we === 1'b1) begin we_cnt++; we_cyc = c; wa = rf_waddr; end
            imem_ack = (c == 4);
        end
        checks++; if (bad_fetch !== 0) begin errors++; $display("FAIL wait_req_stable got %0d bad cycles exp 0", bad_fetch); end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL wait_we_count got %0d exp 1", we_cnt); end
        checks++; if (we_cyc !== 7) begin errors++; $display("FAIL wait_we_cycle got %0d exp 7", we_cyc); end
        checks++; if (wa !== 4'd5) begin errors++; $display("FAIL wait_waddr got %0h exp 5", wa); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL wait_retired got %0h exp 1", retired); end
    endtask

    task automatic test_sequence();
        logic [18:0] prog [8];
        int ev_op [8];
        int ev_wa [8];
        int exp_op [4];
        int exp_wa [4];
        int n_ev;
        int overlap;
        int consec;
        int bad_hold;
        logic prev_pulse;
        prog[0] = enc(5'b00001, 4'd1, 4'd2, 4'd3);
        prog[1] = enc(5'b00010, 4'd4, 4'd5, 4'd6);
        prog[2] = enc(5'b00011, 4'd7, 4'd8, 4'd9);
        prog[3] = enc(5'b00111, 4'd10, 4'd11, 4'd12);
        prog[4] = enc(5'b11111, 4'd0, 4'd0, 4'd0);
        for (int i = 5; i < 8; i++) prog[i] = enc(5'b11111, 4'd0, 4'd0, 4'd0);
        exp_op = '{1, 2, 3, 9};
        exp_wa = '{1, 4, 7, -1};
        for (int i = 0; i < 8; i++) begin ev_op[i] = -1; ev_wa[i] = -1; end
        n_ev = 0; overlap = 0; consec = 0; bad_hold = 0; prev_pulse = 1'b0;
        do_reset();
        imem_ack = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 60 && halted !== 1'b1; c++) begin
            if (rf_we === 1'b1 && illegal === 1'b1) overlap++;
            if ((rf_we === 1'b1 || illegal === 1'b1) && prev_pulse) consec++;
            prev_pulse = (rf_we === 1'b1) || (illegal === 1'b1);
            if (rf_we === 1'b1 && n_ev < 8) begin ev_op[n_ev] = int'(alu_op); ev_wa[n_ev] = int'(rf_waddr); n_ev++; end
            else if (illegal === 1'b1 && n_ev < 8) begin ev_op[n_ev] = 9; n_ev++; end
            imem_rdata = prog[imem_addr[2:0]];
            imem_ack   = imem_req;
            step();
        end
        imem_ack = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL seq_halted got %0b exp 1", halted); end
        checks++; if (n_ev !== 4) begin errors++; $display("FAIL seq_events got %0d exp 4", n_ev); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_op[i] !== exp_op[i]) begin errors++; $display("FAIL seq_op%0d got %0d exp %0d", i, ev_op[i], exp_op[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ev_wa[i] !== exp_wa[i]) begin errors++; $display("FAIL seq_waddr%0d got %0d exp %0d", i, ev_wa[i], exp_wa[i]); end
        end
        checks++; if (overlap !== 0 || consec !== 0) begin errors++; $display("FAIL seq_pulses got overlap %0d consec %0d exp 0 0", overlap, consec); end
        checks++; if (imem_addr !== 8'd4 || retired !== 16'd4) begin errors++; $display("FAIL seq_halt_state got pc %0h ret %0h exp 4 4", imem_addr, retired); end
        imem_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (halted !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0) bad_hold++;
        end
        imem_ack = 1'b0;
        checks++; if (bad_hold !== 0) begin errors++; $display("FAIL seq_hold got %0d bad cycles exp 0", bad_hold); end
        checks++; if (imem_addr !== 8'd4 || retired !== 16'd4) begin errors++; $display("FAIL seq_hold_state got pc %0h ret %0h exp 4 4", imem_addr, retired); end
    endtask

    task automatic test_restart();
        imem_ack = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL restart_flags got halted %0b req %0b exp 0 1", halted, imem_req); end
        checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL restart_pc got %0h exp 0", imem_addr); end
        checks++; if (retired !== 16'd4) begin errors++; $display("FAIL restart_retired got %0h exp 4", retired); end
    endtask

    task automatic test_reset_mid();
        imem_rdata = enc(5'b00001, 4'd9, 4'd10, 4'd11);
        imem_ack   = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        checks++; if (busy !== 1'b1 || alu_op !== 3'b001 || rf_waddr !== 4'd9) begin errors++; $display("FAIL mid_exec got busy %0b op %0h wa %0h exp 1 1 9", busy, alu_op, rf_waddr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || rf_we !== 1'b0 || illegal !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got busy %0b req %0b we %0b ill %0b halt %0b exp 0", busy, imem_req, rf_we, illegal, halted); end
        checks++; if (alu_op !== 3'd0 || {rf_waddr, rf_raddr1, rf_raddr2} !== 12'h000) begin errors++; $display("FAIL mid_rst_decode got op %0h regs %0h exp 0 0", alu_op, {rf_waddr, rf_raddr1, rf_raddr2}); end
        checks++; if (retired !== 16'd0 || imem_addr !== 8'd0) begin errors++; $display("FAIL mid_rst_counters got ret %0h pc %0h exp 0 0", retired, imem_addr); end
        #1;
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = enc(5'b00000, 4'd15, 4'd15, 4'd15);
        for (int c = 0; c < 3; c++) step();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || rf_waddr !== 4'd0) begin errors++; $display("FAIL stray_ack got req %0b busy %0b wa %0h exp 0 0 0", imem_req, busy, rf_waddr); end
    endtask

    task automatic test_wrap();
        int addrs [5];
        int exp_addrs [5];
        int n;
        logic prev_req;
        exp_addrs = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) addrs[i] = -1;
        n = 0; prev_req = 1'b0;
        ack_w   = 1'b0;
        rdata_w = enc(5'b00000, 4'd1, 4'd2, 4'd3);
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            if (req_w === 1'b1 && !prev_req) begin addrs[n] = int'(addr_w); n++; end
            prev_req = (req_w === 1'b1);
            ack_w    = req_w;
            step();
        end
        ack_w = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("FAIL wrap_fetches got %0d exp 5", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (addrs[i] !== exp_addrs[i]) begin errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, addrs[i], exp_addrs[i]); end
        end
        checks++; if (retired_w !== 16'd4) begin errors++; $display("FAIL wrap_retired got %0h exp 4", retired_w); end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        start_w    = 1'b0;
        ack_w      = 1'b0;
        rdata_w    = '0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        test_add();
        test_wait_states();
        test_sequence();
        test_restart();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 19-bit CPU. It fetches instruction words from instruction memory over a request/acknowledge handshake and decodes each 19-bit word into register-file addresses and an ALU operation. It then drives the register-file write strobe for exactly one cycle per retired ALU instruction. It sits between the instruction memory and the existing opcode decode, register file and ALU datapath, and owns the program counter.

## Interface
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, PC value after reset and on restart

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution; sampled only in IDLE or HALT
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (equals pc)
- imem_ack  in  1  fetch data valid; sampled only in FETCH while imem_req=1
- imem_rdata  in  19  instruction word
- rf_raddr1  out  4  source register 1 (ir[9:6])
- rf_raddr2  out  4  source register 2 (ir[5:2])
- rf_waddr  out  4  destination register (ir[13:10])
- rf_we  out  1  register-file write enable, one cycle per ALU instruction
- alu_op  out  3  ALU operation select
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on unknown opcode
- retired  out  16  count of completed instructions, HALT excluded

## Operation
- Instruction format: opcode ir[18:14], rd ir[13:10], rs1 ir[9:6], rs2 ir[5:2]; ir[1:0] ignored.
- Opcodes:
  - 00000 ADD (alu_op 000)
  - 00001 SUB (001)
  - 00010 AND (010)
  - 00011 OR (011)
  - 11111 HALT
  - all others illegal: treated as NOP with illegal pulse
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE: start=1 → FETCH.
  - FETCH: imem_req=1 and imem_addr=pc. On imem_ack=1, ir<=imem_rdata and → DECODE. Otherwise stay; the request stays asserted with a stable address.
  - DECODE: HALT opcode → HALT. Otherwise → EXECUTE.
  - EXECUTE: → WRITEBACK.
  - WRITEBACK:
    - rf_we=1 if the opcode is ALU.
    - illegal=1 if the opcode is unknown.
    - pc <= pc+1, modulo 2^PC_W.
    - retired <= retired+1, modulo 2^16.
    - → FETCH.
  - HALT: halted=1. start=1 sets pc<=RESET_PC, keeps retired, and → FETCH.
- rf_raddr1/2 and rf_waddr are driven from ir in all states.
- alu_op is valid in DECODE, EXECUTE and WRITEBACK for ALU opcodes. It is 000 otherwise.
- All outputs decode from registered state, pc and ir only. There is no combinational path from any input to any output.
- imem_ack outside FETCH is ignored. start in any busy state is ignored.

## Timing
- Reset (asynchronous, any state, mid-fetch included):
  - state=IDLE, pc=RESET_PC, ir=0, retired=0.
  - imem_req=0, rf_we=0, alu_op=000, busy=0, halted=0, illegal=0.
  - imem_addr=RESET_PC, register address outputs=0.
- Minimum latency is 4 cycles per instruction, when imem_ack is high in the first FETCH cycle.
  - Each wait-state cycle on imem_ack adds one cycle.
- From start sampled in IDLE: imem_req rises the next cycle.
  - With immediate ack, rf_we pulses in the 4th cycle after start.
- rf_we and illegal are never high together and never high for more than one consecutive cycle.
- The pc increment and retired increment occur on the WRITEBACK→FETCH edge.
  - The next imem_addr shows the new pc in the first cycle of the following FETCH.
- HALT reached from DECODE: halted rises one cycle after DECODE. pc holds the HALT instruction's address. No rf_we occurs.
- PC wrap: pc=2^PC_W−1 retiring → pc=0, no flag.

## Test plan
- ADD with immediate ack: reset, start, imem_rdata=00000_0011_0001_0010_00, ack held high → FETCH/DECODE/EXECUTE/WRITEBACK. In cycle 4: rf_we=1, rf_waddr=3, rf_raddr1=1, rf_raddr2=2, alu_op=000. Then pc=1, retired=1.
- Wait states: ack delayed 3 cycles → imem_req and imem_addr=0 stable for 4 cycles. The instruction completes 7 cycles after start with one rf_we pulse.
- Opcode sequence SUB, AND, OR, 00111, HALT → alu_op 001, 010, 011, with rf_we each. For 00111: illegal pulse, rf_we=0. HALT: halted=1 with pc=4 and retired=4, and stays halted for 20 cycles.
- Restart: in HALT assert start → pc=RESET_PC, halted=0, and imem_req rises the next cycle. retired is unchanged.
- Reset mid-operation: assert rst during EXECUTE → all outputs at reset values immediately, without waiting for a clock edge. A stray ack while in IDLE is ignored.
- Wrap: PC_W=2, four ADDs retired → imem_addr sequence 0,1,2,3,0.
